// File: rtl/mult_seq_pkg.sv
// ------------------------------------------------------------------
// mult_seq_pkg : shared ALU opcodes and datapath width for mult_seq
// Revision     : 1.0
// ------------------------------------------------------------------
`default_nettype none

package mult_seq_pkg;

  localparam int WORD_W = 32;

  // Opcode values are shared with the ALU control decoder.
  typedef enum logic [1:0] {
    ALU_AND = 2'd0,
    ALU_OR  = 2'd1,
    ALU_ADD = 2'd2
  } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/mult_seq_if.sv
// ------------------------------------------------------------------
// mult_seq_if : start/busy/done handshake and product bus of mult_seq
// Revision    : 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mult_seq_if;
  import mult_seq_pkg::*;

  logic              start;
  logic [WORD_W-1:0] mcand;
  logic [WORD_W-1:0] mplier;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;
  logic              prod_zero;

  modport master (
    output start, mcand, mplier,
    input  busy, done, hi, lo, prod_zero
  );

  modport slave (
    input  start, mcand, mplier,
    output busy, done, hi, lo, prod_zero
  );

endinterface

`default_nettype wire

// File: rtl/ALU32.sv
// ------------------------------------------------------------------
// ALU32    : 32-bit AND/OR/ADD unit with carry-out and zero flag
// Revision : 1.0
// ------------------------------------------------------------------
`default_nettype none

module ALU32
  import mult_seq_pkg::*;
(
  output logic [31:0] result,
  output logic        Cout,
  output logic        zero,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  input  logic [1:0]  opcode
);

  logic [32:0] sum;

  always_comb begin
    sum    = {1'b0, A} + {1'b0, B} + {32'd0, Cin};
    result = '0;
    Cout   = 1'b0;
    case (opcode)
      ALU_AND: result = A & B;
      ALU_OR:  result = A | B;
      ALU_ADD: {Cout, result} = sum;
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

`default_nettype wire

// File: rtl/mult_seq.sv
// ------------------------------------------------------------------
// mult_seq : sequential 32x32 unsigned shift-and-add multiplier, one
//            ALU32 addition per multiplier bit, 64-bit HI/LO result
// Revision : 1.0
// ------------------------------------------------------------------
`default_nettype none

module mult_seq
  import mult_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  mult_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] mcand_q, mcand_d;
  logic [WORD_W-1:0] hi_q, hi_d;
  logic [WORD_W-1:0] lo_q, lo_d;

  logic [WORD_W-1:0] alu_b;
  logic [WORD_W-1:0] alu_sum;
  logic              alu_cout;
  logic              alu_zero_unused;

  // The ALU is driven every cycle; its result only matters in CALC.
  assign alu_b = lo_q[0] ? mcand_q : '0;

  ALU32 u_alu (
    .result (alu_sum),
    .Cout   (alu_cout),
    .zero   (alu_zero_unused),
    .A      (hi_q),
    .B      (alu_b),
    .Cin    (1'b0),
    .opcode (ALU_ADD)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.mcand;
          hi_d    = '0;
          lo_d    = bus.mplier;
          cnt_d   = 5'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        // 65-bit {carry, sum, lo} shifted right by one into {hi, lo}.
        {hi_d, lo_d} = {alu_cout, alu_sum, lo_q[31:1]};
        cnt_d        = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.prod_zero = ({hi_q, lo_q} == 64'd0);

endmodule

`default_nettype wire
